input_row_pingpong_buffer: RTL and testbench

INPUT_ROW_PINGPONG_BUFFER -- requirements
Module: input_row_pingpong_buffer

---
 rtl/input_pp_pkg.sv | 22 ++
 rtl/row_bank.sv | 30 +++
 rtl/input_row_pingpong_buffer.sv | 128 ++++++++++++
 tb/tb_input_row_pingpong_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_pp_pkg.sv
// Shared constants and helpers for the input row ping-pong buffer.
//   padded_w()       : width in bits of a padded output row
//   PAD_L_BIT/_R_BIT : bit positions inside the 2-bit pad-enable field
//   DEF_*            : default parameter values
package input_pp_pkg;

  localparam int unsigned DEF_DW        = 8;
  localparam int unsigned DEF_ROW_LEN   = 32;
  localparam int unsigned DEF_PAD_W     = 1;
  localparam int unsigned DEF_AUTO_SWAP = 0;

  localparam int unsigned PAD_L_BIT = 1;
  localparam int unsigned PAD_R_BIT = 0;

  // Bits in one row including PAD_W pad pixels on each side.
  function automatic int unsigned padded_w(input int unsigned row_len,
                                           input int unsigned pad_w,
                                           input int unsigned dw);
    return (row_len + 2 * pad_w) * dw;
  endfunction

endpackage

// File: rtl/row_bank.sv
// One row of pixel storage.
//   clk   : write clock
//   we    : write enable
//   waddr : pixel index to write
//   wdata : pixel value
//   rdata : whole row, pixel 0 in the most significant DW bits
module row_bank #(
  parameter int unsigned DW      = 8,
  parameter int unsigned ROW_LEN = 32,
  parameter int unsigned AW      = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DW-1:0]         wdata,
  output logic [ROW_LEN*DW-1:0] rdata
);

  logic [DW-1:0] mem [ROW_LEN];

  // Storage is not reset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar g = 0; g < ROW_LEN; g++) begin : g_rd
    assign rdata[(ROW_LEN-1-g)*DW +: DW] = mem[g];
  end

endmodule

// File: rtl/input_row_pingpong_buffer.sv
// Serial-to-parallel row buffer with two ping-pong banks and edge padding.
//   clk, rst           : clock, synchronous active-high reset
//   en                 : global enable, low freezes all state
//   i_data_din/_vld    : serial pixel input; o_din_rdy = write bank has room
//   input_padding      : pad pixel value, latched with i_pad_en at bank swap
//   i_pad_en           : bit1 left pad enable, bit0 right pad enable
//   i_switch_pingpong  : swap request (ignored when AUTO_SWAP=1)
//   o_row_vld/i_row_rdy: row handshake for parallel_data
//   parallel_data      : padded row, pixel 0 at the MSB
//   o_overflow         : sticky, pixel offered while write bank full
module input_row_pingpong_buffer
  import input_pp_pkg::*;
#(
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned ROW_LEN   = DEF_ROW_LEN,
  parameter int unsigned PAD_W     = DEF_PAD_W,
  parameter int unsigned AUTO_SWAP = DEF_AUTO_SWAP
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [DW-1:0]                         i_data_din,
  input  logic                                  i_data_din_vld,
  output logic                                  o_din_rdy,
  input  logic [DW-1:0]                         input_padding,
  input  logic [1:0]                            i_pad_en,
  input  logic                                  i_switch_pingpong,
  output logic                                  o_row_vld,
  input  logic                                  i_row_rdy,
  output logic [padded_w(ROW_LEN,PAD_W,DW)-1:0] parallel_data,
  output logic                                  o_overflow
);

  localparam int unsigned OW     = padded_w(ROW_LEN, PAD_W, DW);
  localparam int unsigned RW     = ROW_LEN * DW;
  localparam int unsigned CW     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam bit          AUTO_C = (AUTO_SWAP != 0);

  logic          wr_sel;
  logic [1:0]    full;
  logic          rd_owned;
  logic [CW-1:0] wcnt;
  logic [DW-1:0] pad_l_q;
  logic [DW-1:0] pad_r_q;

  logic          wr_full_c;
  logic          rd_full_c;
  logic          accept_c;
  logic          last_c;
  logic          swap_c;
  logic          hs_c;
  logic [RW-1:0] bank0_rd_c;
  logic [RW-1:0] bank1_rd_c;
  logic [RW-1:0] rd_data_c;
  logic [OW-1:0] row_c;

  assign wr_full_c = full[wr_sel];
  assign rd_full_c = full[~wr_sel];
  assign o_din_rdy = en & ~wr_full_c;
  assign accept_c  = en & i_data_din_vld & o_din_rdy;
  assign last_c    = (wcnt == CW'(ROW_LEN - 1));
  // Swap needs the read bank empty, handshake needs it full: never both.
  assign swap_c    = en & wr_full_c & ~rd_full_c & (AUTO_C | i_switch_pingpong);
  assign hs_c      = en & o_row_vld & i_row_rdy & rd_full_c & rd_owned;

  row_bank #(.DW(DW), .ROW_LEN(ROW_LEN), .AW(CW)) u_bank0 (
    .clk   (clk),
    .we    (accept_c & ~wr_sel),
    .waddr (wcnt),
    .wdata (i_data_din),
    .rdata (bank0_rd_c)
  );

  row_bank #(.DW(DW), .ROW_LEN(ROW_LEN), .AW(CW)) u_bank1 (
    .clk   (clk),
    .we    (accept_c & wr_sel),
    .waddr (wcnt),
    .wdata (i_data_din),
    .rdata (bank1_rd_c)
  );

  // Read bank is always the one not being written.
  assign rd_data_c = wr_sel ? bank0_rd_c : bank1_rd_c;

  // Padded row: left pads at the MSB end, right pads at the LSB end.
  for (genvar g = 0; g < PAD_W; g++) begin : g_pad
    assign row_c[OW-1-g*DW -: DW]    = pad_l_q;
    assign row_c[(PAD_W-1-g)*DW +: DW] = pad_r_q;
  end
  assign row_c[OW-1-PAD_W*DW -: RW] = rd_data_c;

  // Bank control, padding latch, output row register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel        <= 1'b0;
      full          <= 2'b00;
      rd_owned      <= 1'b0;
      wcnt          <= '0;
      pad_l_q       <= '0;
      pad_r_q       <= '0;
      o_row_vld     <= 1'b0;
      o_overflow    <= 1'b0;
      parallel_data <= '0;
    end else begin
      if (accept_c) begin
        wcnt <= last_c ? '0 : wcnt + CW'(1);
        if (last_c) full[wr_sel] <= 1'b1;
      end
      if (swap_c) begin
        wr_sel   <= ~wr_sel;
        rd_owned <= 1'b1;
        pad_l_q  <= i_pad_en[PAD_L_BIT] ? input_padding : '0;
        pad_r_q  <= i_pad_en[PAD_R_BIT] ? input_padding : '0;
      end
      if (hs_c) begin
        full[~wr_sel] <= 1'b0;
        rd_owned      <= 1'b0;
      end
      if (en & i_data_din_vld & wr_full_c) o_overflow <= 1'b1;
      if (en) begin
        o_row_vld <= rd_full_c & rd_owned;
        // Read bank and pads are static while owned, so the row holds stable.
        if (rd_full_c & rd_owned) parallel_data <= row_c;
      end
    end
  end

endmodule

// File: tb/tb_input_row_pingpong_buffer.sv
// Directed bench: one AUTO_SWAP=1 and one AUTO_SWAP=0 instance share stimulus.
module tb_input_row_pingpong_buffer;

  localparam int unsigned OW = 272;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    din;
  logic          vld;
  logic [7:0]    pad;
  logic [1:0]    pad_en;
  logic          sw;
  logic          row_rdy;

  logic          rdy_a, row_vld_a, ovf_a;
  logic [OW-1:0] pd_a;
  logic          rdy_m, row_vld_m, ovf_m;
  logic [OW-1:0] pd_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_row_pingpong_buffer #(.DW(8), .ROW_LEN(32), .PAD_W(1), .AUTO_SWAP(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .i_data_din(din), .i_data_din_vld(vld),
    .o_din_rdy(rdy_a), .input_padding(pad), .i_pad_en(pad_en),
    .i_switch_pingpong(sw), .o_row_vld(row_vld_a), .i_row_rdy(row_rdy),
    .parallel_data(pd_a), .o_overflow(ovf_a)
  );

  input_row_pingpong_buffer #(.DW(8), .ROW_LEN(32), .PAD_W(1), .AUTO_SWAP(0)) dut_m (
    .clk(clk), .rst(rst), .en(en), .i_data_din(din), .i_data_din_vld(vld),
    .o_din_rdy(rdy_m), .input_padding(pad), .i_pad_en(pad_en),
    .i_switch_pingpong(sw), .o_row_vld(row_vld_m), .i_row_rdy(row_rdy),
    .parallel_data(pd_m), .o_overflow(ovf_m)
  );

  function automatic logic [OW-1:0] mk_row(input logic [7:0] lp,
                                           input logic [7:0] base,
                                           input logic [7:0] rp);
    logic [OW-1:0] r;
    r = '0;
    r[OW-1 -: 8] = lp;
    for (int k = 0; k < 32; k++) r[OW-9-8*k -: 8] = base + 8'(k);
    r[7:0] = rp;
    return r;
  endfunction

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; vld = 1'b0; sw = 1'b0; row_rdy = 1'b0; din = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 32 back-to-back pixels base..base+31; sw pulsed alongside pixel sw_idx.
  task automatic push_row(input logic [7:0] base, input int sw_idx);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      din = base + 8'(i);
      vld = 1'b1;
      sw  = (i == sw_idx);
    end
    @(negedge clk);
    vld = 1'b0;
    sw  = 1'b0;
  endtask

  task automatic pulse_switch();
    @(negedge clk);
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", rdy_m); end
    checks++; if (row_vld_m !== 1'b0) begin errors++; $display("FAIL reset_row_vld got %b want 0", row_vld_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_m); end
    checks++; if (pd_m !== '0) begin errors++; $display("FAIL reset_data got %h want 0", pd_m); end
    checks++; if (row_vld_a !== 1'b0) begin errors++; $display("FAIL reset_row_vld_a got %b want 0", row_vld_a); end
  endtask

  task automatic test_auto_swap();
    do_reset();
    pad = 8'h81; pad_en = 2'b11;
    push_row(8'h01, -1);
    // One edge after the last accept: full, not yet swapped.
    checks++; if (row_vld_a !== 1'b0) begin errors++; $display("FAIL auto_vld_e1 got %b want 0", row_vld_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL auto_rdy_full got %b want 0", rdy_a); end
    @(negedge clk);
    checks++; if (row_vld_a !== 1'b0) begin errors++; $display("FAIL auto_vld_e2 got %b want 0", row_vld_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL auto_rdy_swapped got %b want 1", rdy_a); end
    @(negedge clk);
    checks++; if (row_vld_a !== 1'b1) begin errors++; $display("FAIL auto_vld_rise got %b want 1", row_vld_a); end
    checks++; if (pd_a !== mk_row(8'h81, 8'h01, 8'h81)) begin errors++; $display("FAIL auto_data got %h want %h", pd_a, mk_row(8'h81, 8'h01, 8'h81)); end
    checks++; if (row_vld_m !== 1'b0) begin errors++; $display("FAIL manual_no_swap got %b want 0", row_vld_m); end
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL manual_rdy_full got %b want 0", rdy_m); end
    row_rdy = 1'b1;
    @(negedge clk);
    row_rdy = 1'b0;
    checks++; if (row_vld_a !== 1'b1) begin errors++; $display("FAIL auto_vld_after_hs got %b want 1", row_vld_a); end
    @(negedge clk);
    checks++; if (row_vld_a !== 1'b0) begin errors++; $display("FAIL auto_vld_fall got %b want 0", row_vld_a); end
  endtask

  task automatic test_manual_overflow();
    do_reset();
    pad = 8'h55; pad_en = 2'b00;
    push_row(8'h40, -1);
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL man_rdy_row1 got %b want 0", rdy_m); end
    repeat (2) @(negedge clk);
    checks++; if (row_vld_m !== 1'b0) begin errors++; $display("FAIL man_wait_swap got %b want 0", row_vld_m); end
    pulse_switch();
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL man_rdy_after_swap got %b want 1", rdy_m); end
    @(negedge clk);
    checks++; if (row_vld_m !== 1'b1) begin errors++; $display("FAIL man_vld got %b want 1", row_vld_m); end
    checks++; if (pd_m !== mk_row(8'h00, 8'h40, 8'h00)) begin errors++; $display("FAIL man_data got %h want %h", pd_m, mk_row(8'h00, 8'h40, 8'h00)); end
    push_row(8'h60, -1);
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL man_rdy_row2 got %b want 0", rdy_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL man_ovf_early got %b want 0", ovf_m); end
    din = 8'h99; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL man_ovf_set got %b want 1", ovf_m); end
    checks++; if (pd_m !== mk_row(8'h00, 8'h40, 8'h00)) begin errors++; $display("FAIL man_data_stable got %h want %h", pd_m, mk_row(8'h00, 8'h40, 8'h00)); end
    repeat (2) @(negedge clk);
    checks++; if (ovf_m !== 1'b1) begin errors++; $display("FAIL man_ovf_sticky got %b want 1", ovf_m); end
  endtask

  task automatic test_padding();
    do_reset();
    pad = 8'hFF; pad_en = 2'b10;
    push_row(8'h00, -1);
    pulse_switch();
    pad = 8'h33; pad_en = 2'b11;
    @(negedge clk);
    checks++; if (row_vld_m !== 1'b1) begin errors++; $display("FAIL pad_vld got %b want 1", row_vld_m); end
    checks++; if (pd_m !== mk_row(8'hFF, 8'h00, 8'h00)) begin errors++; $display("FAIL pad_data got %h want %h", pd_m, mk_row(8'hFF, 8'h00, 8'h00)); end
    checks++; if (pd_a !== mk_row(8'hFF, 8'h00, 8'h00)) begin errors++; $display("FAIL pad_data_auto got %h want %h", pd_a, mk_row(8'hFF, 8'h00, 8'h00)); end
    repeat (3) @(negedge clk);
    checks++; if (pd_m !== mk_row(8'hFF, 8'h00, 8'h00)) begin errors++; $display("FAIL pad_hold got %h want %h", pd_m, mk_row(8'hFF, 8'h00, 8'h00)); end
  endtask

  task automatic test_early_switch();
    do_reset();
    pad = 8'h77; pad_en = 2'b00;
    push_row(8'hC0, 5);
    repeat (3) @(negedge clk);
    checks++; if (row_vld_m !== 1'b0) begin errors++; $display("FAIL early_no_swap got %b want 0", row_vld_m); end
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL early_still_full got %b want 0", rdy_m); end
    pulse_switch();
    @(negedge clk);
    checks++; if (row_vld_m !== 1'b1) begin errors++; $display("FAIL early_vld_after_pulse got %b want 1", row_vld_m); end
    checks++; if (pd_m !== mk_row(8'h00, 8'hC0, 8'h00)) begin errors++; $display("FAIL early_data got %h want %h", pd_m, mk_row(8'h00, 8'hC0, 8'h00)); end
  endtask

  task automatic test_reset_mid_row();
    checks++; if (row_vld_m !== 1'b1) begin errors++; $display("FAIL mid_pending got %b want 1", row_vld_m); end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      din = 8'hE0 + 8'(i);
      vld = 1'b1;
    end
    do_reset();
    checks++; if (row_vld_m !== 1'b0) begin errors++; $display("FAIL mid_vld got %b want 0", row_vld_m); end
    checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b want 1", rdy_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", ovf_m); end
    checks++; if (pd_m !== '0) begin errors++; $display("FAIL mid_data got %h want 0", pd_m); end
    pad_en = 2'b00;
    push_row(8'hA0, -1);
    pulse_switch();
    @(negedge clk);
    checks++; if (row_vld_m !== 1'b1) begin errors++; $display("FAIL mid_new_vld got %b want 1", row_vld_m); end
    checks++; if (pd_m !== mk_row(8'h00, 8'hA0, 8'h00)) begin errors++; $display("FAIL mid_new_data got %h want %h", pd_m, mk_row(8'h00, 8'hA0, 8'h00)); end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    pad_en = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din = 8'h10 + 8'(i);
      vld = 1'b1;
    end
    @(negedge clk);
    en = 1'b0; din = 8'hEE; vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL freeze_rdy cyc %0d got %b want 0", i, rdy_m); end
    end
    for (int i = 10; i < 32; i++) begin
      en  = 1'b1;
      din = 8'h10 + 8'(i);
      vld = 1'b1;
      @(negedge clk);
    end
    vld = 1'b0;
    checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL freeze_full_at_32 got %b want 0", rdy_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL freeze_ovf got %b want 0", ovf_m); end
    pulse_switch();
    @(negedge clk);
    checks++; if (row_vld_m !== 1'b1) begin errors++; $display("FAIL freeze_vld got %b want 1", row_vld_m); end
    checks++; if (pd_m !== mk_row(8'h00, 8'h10, 8'h00)) begin errors++; $display("FAIL freeze_data got %h want %h", pd_m, mk_row(8'h00, 8'h10, 8'h00)); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = '0; vld = 1'b0; pad = '0; pad_en = 2'b00;
    sw = 1'b0; row_rdy = 1'b0;
    test_reset();
    test_auto_swap();
    test_manual_overflow();
    test_padding();
    test_early_switch();
    test_reset_mid_row();
    test_enable_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
